// File: rtl/psum_requant_fifo_pkg.sv
// Shared Q-format constants and the FIFO entry layout.
// The PE array uses the same definitions, so a requantized element keeps one
// layout everywhere it is stored or moved.
package psum_requant_fifo_pkg;

    // Output element format: Q8.8.
    localparam int Q_DATA_WIDTH = 16;
    // Partial-sum format from the PE array: Q16.16.
    localparam int Q_ACC_WIDTH  = 32;
    // Fraction bits dropped when going from accumulator to data format.
    localparam int Q_FRAC_BITS  = 8;
    // Default depth of the output buffer.
    localparam int Q_FIFO_DEPTH = 8;

    // One buffered result: the clamp flag travels with the data.
    typedef struct packed {
        logic                    sat;
        logic [Q_DATA_WIDTH-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/psum_requant_fifo_if.sv
// Stream interface of the requantizer.
// The input side (valid_in/result_in) has no backpressure. The output side is
// a valid/ready handshake on the head of the output buffer.
// master = the producer/consumer environment, slave = the requantizer.
interface psum_requant_fifo_if #(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 16
) ();

    logic                  valid_in;
    logic [ACC_WIDTH-1:0]  result_in;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_sat;

    modport master (
        output valid_in,
        output result_in,
        output out_ready,
        input  out_valid,
        input  out_data,
        input  out_sat
    );

    modport slave (
        input  valid_in,
        input  result_in,
        input  out_ready,
        output out_valid,
        output out_data,
        output out_sat
    );

endinterface

// File: rtl/psum_requant_fifo_sync_fifo.sv
// Single-clock FIFO with an occupancy counter.
// A push into a full FIFO is still accepted when a pop happens on the same
// edge, because the popped slot is the one being refilled. A push into a full
// FIFO without a pop is dropped and reported on push_drop.
// Memory is not reset; only the pointers and the level are.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 17
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop_req,
    output logic [WIDTH-1:0]         dout,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     push_ok,
    output logic                     push_drop
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             full;
    logic             do_pop;

    assign full      = (count == LW'(DEPTH));
    assign valid     = (count != '0);
    assign do_pop    = valid && pop_req;
    assign push_ok   = push && (!full || do_pop);
    assign push_drop = push && full && !do_pop;
    assign dout      = mem[rd_ptr];
    assign level     = count;

    // Storage array: write the accepted element at the write pointer.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); the level counter tells full from empty.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push_ok, do_pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/psum_requant_fifo.sv
// Requantizer for PE-array partial sums: Q16.16 -> Q8.8 with round-half-up,
// clamp to the output range, then buffer in a small FIFO.
// Stage 1 rounds and shifts. Stage 2 clamps. The FIFO write happens on the
// following edge, so a result appears at the output three cycles after it
// enters.
module psum_requant_fifo
    import psum_requant_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = Q_DATA_WIDTH,
    parameter int ACC_WIDTH  = Q_ACC_WIDTH,
    parameter int FRAC_BITS  = Q_FRAC_BITS,
    parameter int FIFO_DEPTH = Q_FIFO_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    psum_requant_fifo_if.slave            bus,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow_err,
    output logic [15:0]                   sat_cnt
);

    // Rounding sum is one bit wider than the accumulator so +half never wraps.
    localparam int RW = ACC_WIDTH + 1;

    localparam logic signed [RW-1:0] RND_HALF =
        {{(RW-FRAC_BITS){1'b0}}, 1'b1, {(FRAC_BITS-1){1'b0}}};
    localparam logic signed [RW-1:0] SAT_MAX =
        {{(RW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN =
        {{(RW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

    // The entry struct is shared with the PE array, so its width is fixed by the package.
    if (DATA_WIDTH != Q_DATA_WIDTH) begin : g_width_check
        $error("psum_requant_fifo: DATA_WIDTH must equal the package Q_DATA_WIDTH");
    end

    logic signed [RW-1:0]   rnd_sum;
    logic signed [RW-1:0]   rnd_shift;
    logic                   s1_valid;
    logic signed [RW-1:0]   s1_data;
    logic [DATA_WIDTH-1:0]  clamp_data;
    logic                   clamp_sat;
    logic                   s2_valid;
    fifo_entry_t            s2_entry;
    fifo_entry_t            head;
    logic                   push_ok;
    logic                   push_drop;

    // Add half an LSB of the output format, then drop the fraction bits arithmetically.
    assign rnd_sum   = $signed({bus.result_in[ACC_WIDTH-1], bus.result_in}) + RND_HALF;
    assign rnd_shift = rnd_sum >>> FRAC_BITS;

    // Stage 1 valid advances every cycle; reset and flush both empty the stage.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            s1_valid <= 1'b0;
        end else begin
            s1_valid <= bus.valid_in;
        end
    end

    // Stage 1 data only loads on a valid input so idle cycles do not toggle it.
    always_ff @(posedge clk) begin
        if (bus.valid_in) begin
            s1_data <= rnd_shift;
        end
    end

    // Clamp the rounded value into the signed output range and flag when clamping happened.
    always_comb begin
        clamp_data = s1_data[DATA_WIDTH-1:0];
        clamp_sat  = 1'b0;
        if (s1_data > SAT_MAX) begin
            clamp_data = SAT_MAX[DATA_WIDTH-1:0];
            clamp_sat  = 1'b1;
        end else if (s1_data < SAT_MIN) begin
            clamp_data = SAT_MIN[DATA_WIDTH-1:0];
            clamp_sat  = 1'b1;
        end
    end

    // Stage 2 valid follows stage 1 every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            s2_valid <= 1'b0;
        end else begin
            s2_valid <= s1_valid;
        end
    end

    // Stage 2 entry only loads when stage 1 holds a result.
    always_ff @(posedge clk) begin
        if (s1_valid) begin
            s2_entry.sat  <= clamp_sat;
            s2_entry.data <= clamp_data;
        end
    end

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH ($bits(fifo_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (flush),
        .push      (s2_valid),
        .din       (s2_entry),
        .pop_req   (bus.out_ready),
        .dout      (head),
        .valid     (bus.out_valid),
        .level     (fifo_level),
        .push_ok   (push_ok),
        .push_drop (push_drop)
    );

    assign bus.out_data = head.data;
    assign bus.out_sat  = head.sat;

    // Status: sticky drop flag and a saturating count of clamped results that got buffered.
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            overflow_err <= 1'b0;
            sat_cnt      <= '0;
        end else begin
            if (push_drop) begin
                overflow_err <= 1'b1;
            end
            if (push_ok && s2_entry.sat && (sat_cnt != 16'hFFFF)) begin
                sat_cnt <= sat_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_psum_requant_fifo.sv
// Bench for psum_requant_fifo: directed corner cases followed by randomized
// traffic. Expected outputs come from an arithmetic reference model and wait
// in a scoreboard queue until the output handshake takes them.
module tb_psum_requant_fifo;
    import psum_requant_fifo_pkg::*;

    localparam int DW    = 16;
    localparam int AW    = 32;
    localparam int FB    = 8;
    localparam int DEPTH = 8;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic [LW-1:0] fifo_level;
    logic          overflow_err;
    logic [15:0]   sat_cnt;

    psum_requant_fifo_if #(.ACC_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    psum_requant_fifo #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .FRAC_BITS  (FB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .bus          (bus),
        .fifo_level   (fifo_level),
        .overflow_err (overflow_err),
        .sat_cnt      (sat_cnt)
    );

    always #5 clk = ~clk;

    int          compared   = 0;
    int          mismatched = 0;
    bit          checkEn    = 1'b0;

    logic [DW:0]   expQ[$];
    int            modelLevel    = 0;
    bit            modelOverflow = 1'b0;
    int            modelSatCnt   = 0;
    bit            pipeV[2]      = '{1'b0, 1'b0};
    logic [AW-1:0] pipeD[2];

    // Mathematical floor division for a positive divisor.
    function automatic longint floorDiv(input longint a, input longint b);
        longint q;
        q = a / b;
        if ((a % b != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    // Reference requantization: real-valued round-half-up, then clamp to the output range.
    function automatic logic [DW:0] requantRef(input logic [AW-1:0] x);
        longint v;
        longint r;
        longint maxV;
        longint minV;
        v    = longint'($signed(x));
        maxV = (longint'(1) << (DW - 1)) - 1;
        minV = -(longint'(1) << (DW - 1));
        r    = floorDiv(v + (longint'(1) << (FB - 1)), longint'(1) << FB);
        if (r > maxV) return {1'b1, DW'(maxV)};
        if (r < minV) return {1'b1, DW'(minV)};
        return {1'b0, DW'(r)};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: a result lands in the buffer two edges after it is sampled.
    // Buffer occupancy is counted, accepted results are queued for the monitor.
    always @(posedge clk) begin
        bit          popNow;
        logic [DW:0] e;
        if (!rst_n || flush) begin
            modelLevel    = 0;
            modelOverflow = 1'b0;
            modelSatCnt   = 0;
            pipeV         = '{1'b0, 1'b0};
            expQ.delete();
        end else begin
            popNow = (modelLevel != 0) && bus.out_ready;
            if (pipeV[1]) begin
                if ((modelLevel < DEPTH) || popNow) begin
                    e = requantRef(pipeD[1]);
                    expQ.push_back(e);
                    modelLevel++;
                    if (e[DW] && (modelSatCnt < 65535)) modelSatCnt++;
                end else begin
                    modelOverflow = 1'b1;
                end
            end
            if (popNow) modelLevel--;
            pipeV[1] = pipeV[0];
            pipeD[1] = pipeD[0];
            pipeV[0] = bus.valid_in;
            pipeD[0] = bus.result_in;
        end
    end

    // Monitor: status against the model every cycle, head element against the scoreboard on each pop.
    always @(negedge clk) begin
        logic [DW:0] e;
        if (checkEn && rst_n) begin
            checkOutput("out_valid", 64'(bus.out_valid), 64'(modelLevel != 0));
            checkOutput("fifo_level", 64'(fifo_level), 64'(modelLevel));
            checkOutput("overflow_err", 64'(overflow_err), 64'(modelOverflow));
            checkOutput("sat_cnt", 64'(sat_cnt), 64'(modelSatCnt));
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    compared++;
                    mismatched++;
                    $display("[TB] FAIL unexpected_output: got %0h expected none at %0t", bus.out_data, $time);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("out_data", 64'(bus.out_data), 64'(e[DW-1:0]));
                    checkOutput("out_sat", 64'(bus.out_sat), 64'(e[DW]));
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input bit v, input logic [AW-1:0] d);
        bus.valid_in  = v;
        bus.result_in = d;
        @(posedge clk);
        #1;
        bus.valid_in  = 1'b0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    function automatic logic [AW-1:0] randomValue();
        logic [AW-1:0] t;
        int            s;
        case ($urandom_range(0, 3))
            0: t = $urandom();
            1: begin
                s = int'($urandom_range(0, 32'h00FF_FFFF)) - 32'sh0080_0000;
                t = AW'(s);
            end
            2: begin
                t = $urandom();
                t[7:0]   = 8'h80;
                t[31:24] = {8{t[23]}};
            end
            default: begin
                t = ($urandom_range(0, 1) != 0) ? 32'h007F_FF00 : 32'hFF80_0000;
                t = t + AW'($urandom_range(0, 511)) - 32'd256;
            end
        endcase
        return t;
    endfunction

    int readyPct[6] = '{90, 30, 100, 10, 60, 50};

    initial begin
        int guard;
        bus.valid_in  = 1'b0;
        bus.result_in = '0;
        bus.out_ready = 1'b0;
        flush         = 1'b0;
        rst_n         = 1'b0;
        idle(2);
        checkOutput("reset out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("reset fifo_level", 64'(fifo_level), 64'(0));
        checkOutput("reset overflow_err", 64'(overflow_err), 64'(0));
        checkOutput("reset sat_cnt", 64'(sat_cnt), 64'(0));
        rst_n   = 1'b1;
        checkEn = 1'b1;

        // Single result: output appears exactly three edges after it is sampled.
        bus.out_ready = 1'b1;
        applyStimulus(1'b1, 32'h0001_8000);
        idle(1);
        checkOutput("latency early out_valid", 64'(bus.out_valid), 64'(0));
        idle(1);
        checkOutput("latency out_valid", 64'(bus.out_valid), 64'(1));
        checkOutput("latency out_data", 64'(bus.out_data), 64'(16'h0180));
        checkOutput("latency out_sat", 64'(bus.out_sat), 64'(0));
        idle(1);
        checkOutput("after pop out_valid", 64'(bus.out_valid), 64'(0));

        // Rounding ties and saturation in both directions.
        applyStimulus(1'b1, 32'h0000_0080);
        applyStimulus(1'b1, 32'hFFFF_FF80);
        applyStimulus(1'b1, 32'h0000_017F);
        idle(6);
        applyStimulus(1'b1, 32'h0100_0000);
        applyStimulus(1'b1, 32'hFF00_0000);
        applyStimulus(1'b1, 32'h007F_FF7F);
        applyStimulus(1'b1, 32'h007F_FF80);
        idle(6);
        checkOutput("sat_cnt after clamps", 64'(sat_cnt), 64'(3));

        // Overflow: nine results into an eight-deep buffer with the consumer stalled.
        bus.out_ready = 1'b0;
        for (int i = 1; i <= 9; i++) applyStimulus(1'b1, AW'(i * 256));
        idle(4);
        checkOutput("overflow fifo_level", 64'(fifo_level), 64'(8));
        checkOutput("overflow flag", 64'(overflow_err), 64'(1));
        bus.out_ready = 1'b1;
        idle(10);
        doReset();

        // Full buffer with simultaneous push and pop across pointer wrap.
        bus.out_ready = 1'b0;
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, AW'((20 + i) * 256));
        idle(4);
        for (int i = 0; i < 20; i++) begin
            if (i == 2) bus.out_ready = 1'b1;
            applyStimulus(1'b1, AW'((100 + i) * 256));
        end
        checkOutput("full stream overflow_err", 64'(overflow_err), 64'(0));
        idle(12);
        doReset();

        // Flush with results both buffered and still in the pipeline.
        bus.out_ready = 1'b0;
        applyStimulus(1'b1, 32'h7F00_0000);
        for (int i = 1; i < 5; i++) applyStimulus(1'b1, AW'(i * 512));
        idle(3);
        applyStimulus(1'b1, 32'h0000_1000);
        applyStimulus(1'b1, 32'h0000_2000);
        flush = 1'b1;
        applyStimulus(1'b1, 32'h0000_3000);
        flush = 1'b0;
        checkOutput("flush out_valid", 64'(bus.out_valid), 64'(0));
        checkOutput("flush fifo_level", 64'(fifo_level), 64'(0));
        checkOutput("flush overflow_err", 64'(overflow_err), 64'(0));
        checkOutput("flush sat_cnt", 64'(sat_cnt), 64'(0));
        bus.out_ready = 1'b1;
        idle(6);

        // Randomized traffic with varying consumer throughput, rare flushes and resets.
        for (int seg = 0; seg < 6; seg++) begin
            for (int c = 0; c < 100; c++) begin
                bus.out_ready = ($urandom_range(0, 99) < readyPct[seg]);
                flush         = ($urandom_range(0, 99) == 0);
                rst_n         = ($urandom_range(0, 199) != 0);
                applyStimulus($urandom_range(0, 9) < 7, randomValue());
                flush = 1'b0;
                rst_n = 1'b1;
            end
        end

        // Drain everything still in flight.
        bus.out_ready = 1'b1;
        idle(4);
        guard = 0;
        while (bus.out_valid && (guard < 50)) begin
            idle(1);
            guard++;
        end
        checkOutput("drain completes", 64'(bus.out_valid), 64'(0));
        checkOutput("scoreboard empty", 64'(expQ.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
